// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath mux selects, ALU controls, condition codes and DP commands.
package mc_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/cond_unit.sv
// Condition evaluation against the NZCV flags register, plus a one-cycle
// delayed copy of the result used to gate the write enables.
import mc_pkg::*;

module cond_unit #(
    parameter int NV_EXECUTES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    output logic       CondEx,
    output logic       cond_ex_q
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = (NV_EXECUTES != 0);
        endcase
    end

    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = CondEx;
        if (FlagW[1] && CondEx) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0] && CondEx) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: sequences the shared-ALU / single-memory datapath
// and gates architectural writes with the registered condition result.
import mc_pkg::*;

module mc_controller #(
    parameter int STATE_W     = 4,
    parameter int NV_EXECUTES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               RegWrite,
    output logic [STATE_W-1:0] dbg_state
);

    state_e      state_q, state_d;
    logic [3:0]  cond, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        unused_rn;

    logic        next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic        adr_src, alu_src_a;
    logic [1:0]  alu_src_b, result_src, alu_ctrl, flag_w;
    logic        cond_ex, cond_ex_q;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Illegal codes fall into the default arm: back to FETCH, nothing enabled.
    always_comb begin
        state_d    = S_FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RM;
        result_src = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                next_pc    = 1'b1;
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                state_d = S_ALUWB;
                alu_op  = 1'b1;
            end
            S_EXECI: begin
                state_d   = S_ALUWB;
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        flag_w   = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                CMD_ADD: alu_ctrl = ALU_ADD;
                CMD_SUB: alu_ctrl = ALU_SUB;
                CMD_AND: alu_ctrl = ALU_AND;
                CMD_ORR: alu_ctrl = ALU_ORR;
                default: alu_ctrl = ALU_ADD;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ((funct[4:1] == CMD_ADD) | (funct[4:1] == CMD_SUB));
        end
    end

    cond_unit #(
        .NV_EXECUTES(NV_EXECUTES)
    ) u_cond (
        .clk       (clk),
        .reset     (reset),
        .Cond      (cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (flag_w),
        .CondEx    (cond_ex),
        .cond_ex_q (cond_ex_q)
    );

    // Writes use the condition registered one cycle earlier, before any flag update.
    assign PCWrite    = ~reset & (next_pc | (cond_ex_q & (branch | (reg_w & (rd == 4'hF)))));
    assign RegWrite   = ~reset & reg_w & cond_ex_q;
    assign MemWrite   = ~reset & mem_w & cond_ex_q;
    assign IRWrite    = ~reset & ir_write;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_ctrl;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ImmSrc     = op;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};
    assign dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mc_controller;

    localparam int NV = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    mc_controller #(.STATE_W(4), .NV_EXECUTES(NV)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mode = 0;          // 0 no check, 1 reset cycle, 2 full check
    logic [3:0]  m_flags = 4'b0000; // N Z C V
    int          step = 0;
    int          len = 2;
    int          seq[5];
    logic        m_exec = 1'b0;
    logic [19:0] cur = 20'h0;
    logic [19:0] dir_q[$];
    int          af_fix = -1;

    logic [3:0]  e_state;
    logic        e_pcw, e_adr, e_memw, e_irw, e_regw, e_srca;
    logic [1:0]  e_res, e_alu, e_srcb, e_imm, e_regsrc;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n = f[3];
        logic z = f[2];
        logic cc = f[1];
        logic v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return NV != 0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Instruction class determines the list of visited states.
    task automatic plan(input logic [19:0] ins);
        seq[0] = 0;
        seq[1] = 1;
        case (ins[15:14])
            2'b01: begin
                seq[2] = 2;
                if (ins[8]) begin seq[3] = 3; seq[4] = 4; len = 5; end
                else begin seq[3] = 5; len = 4; end
            end
            2'b00: begin seq[2] = ins[13] ? 7 : 6; seq[3] = 8; len = 4; end
            2'b10: begin seq[2] = 9; len = 3; end
            default: len = 2;
        endcase
    endtask

    task automatic set_exp(input int st);
        logic rd15 = (cur[3:0] == 4'hF);
        e_state = 4'(st);
        e_pcw = 0; e_adr = 0; e_memw = 0; e_irw = 0; e_regw = 0; e_srca = 0;
        e_res = 0; e_alu = 0; e_srcb = 0;
        e_imm = cur[15:14];
        e_regsrc = {cur[15:14] == 2'b01, cur[15:14] == 2'b10};
        case (st)
            0: begin e_pcw = 1; e_irw = 1; e_srca = 1; e_srcb = 2; e_res = 2; end
            1: begin e_srca = 1; e_srcb = 2; e_res = 2; end
            2: e_srcb = 1;
            3: e_adr = 1;
            4: begin e_res = 1; e_regw = m_exec; e_pcw = m_exec && rd15; end
            5: begin e_adr = 1; e_memw = m_exec; end
            6: e_alu = alu_of(cur[12:9]);
            7: begin e_srcb = 1; e_alu = alu_of(cur[12:9]); end
            8: begin e_regw = m_exec; e_pcw = m_exec && rd15; end
            default: begin e_srcb = 1; e_res = 2; e_pcw = m_exec; end
        endcase
    endtask

    function automatic logic [19:0] rand_instr();
        logic [19:0] x = 20'($urandom);
        if ($urandom_range(0, 1) == 1) x[19:16] = 4'hE;
        return x;
    endfunction

    task automatic run_cycle(input logic rst_in);
        int st;
        @(negedge clk);
        reset = rst_in;
        ALUFlags = (af_fix >= 0) ? 4'(af_fix) : 4'($urandom);
        if (rst_in) begin
            mode = 1;
            m_flags = 4'b0000;
            step = 0;
            return;
        end
        if (step == 0) begin
            if (dir_q.size() > 0) cur = dir_q.pop_front();
            else cur = rand_instr();
            Instr = cur;
            plan(cur);
            m_exec = cond_ok(cur[19:16], m_flags);
        end
        st = seq[step];
        set_exp(st);
        mode = 2;
        if ((st == 6 || st == 7) && m_exec && cur[8]) begin
            m_flags[3:2] = ALUFlags[3:2];
            if (cur[12:9] == 4'b0100 || cur[12:9] == 4'b0010) m_flags[1:0] = ALUFlags[1:0];
        end
        step = (step + 1 == len) ? 0 : step + 1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #2;
        if (mode == 1) begin
            chk("rst_pcwrite", 32'(PCWrite), 0);
            chk("rst_memwrite", 32'(MemWrite), 0);
            chk("rst_regwrite", 32'(RegWrite), 0);
            chk("rst_irwrite", 32'(IRWrite), 0);
        end else if (mode == 2) begin
            chk("state", 32'(dbg_state), 32'(e_state));
            chk("pcwrite", 32'(PCWrite), 32'(e_pcw));
            chk("adrsrc", 32'(AdrSrc), 32'(e_adr));
            chk("memwrite", 32'(MemWrite), 32'(e_memw));
            chk("irwrite", 32'(IRWrite), 32'(e_irw));
            chk("resultsrc", 32'(ResultSrc), 32'(e_res));
            chk("alucontrol", 32'(ALUControl), 32'(e_alu));
            chk("alusrca", 32'(ALUSrcA), 32'(e_srca));
            chk("alusrcb", 32'(ALUSrcB), 32'(e_srcb));
            chk("immsrc", 32'(ImmSrc), 32'(e_imm));
            chk("regsrc", 32'(RegSrc), 32'(e_regsrc));
            chk("regwrite", 32'(RegWrite), 32'(e_regw));
        end
    end

    // ---------------- directed traces ----------------
    logic [3:0] tr_st[5];
    logic       tr_pcw[5], tr_regw[5], tr_memw[5], tr_adr[5], tr_irw[5];
    logic [1:0] tr_srcb[5], tr_alu[5];

    task automatic trace(input logic [19:0] ins, input int n);
        dir_q.push_back(ins);
        for (int i = 0; i < n; i++) begin
            run_cycle(1'b0);
            #3;
            tr_st[i] = dbg_state;  tr_pcw[i] = PCWrite;  tr_regw[i] = RegWrite;
            tr_memw[i] = MemWrite; tr_adr[i] = AdrSrc;   tr_irw[i] = IRWrite;
            tr_srcb[i] = ALUSrcB;  tr_alu[i] = ALUControl;
        end
    endtask

    task automatic chk_states(input string name, input int n, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
        int e[5] = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < n; i++) chk($sformatf("%s_state%0d", name, i), 32'(tr_st[i]), e[i]);
    endtask

    initial begin
        reset = 1'b1;
        Instr = 20'h0;
        ALUFlags = 4'h0;
        run_cycle(1'b1);
        run_cycle(1'b1);

        trace(20'hE5901, 5);
        chk("post_rst_state", 32'(tr_st[0]), 0);
        chk("post_rst_irwrite", 32'(tr_irw[0]), 1);
        chk("post_rst_pcwrite", 32'(tr_pcw[0]), 1);
        chk_states("ldr", 5, 0, 1, 2, 3, 4);
        for (int i = 0; i < 5; i++) chk($sformatf("ldr_regw%0d", i), 32'(tr_regw[i]), (i == 4) ? 1 : 0);
        chk("ldr_adrsrc_memrd", 32'(tr_adr[3]), 1);
        chk("ldr_srcb_memadr", 32'(tr_srcb[2]), 1);

        trace(20'hE5801, 4);
        chk_states("str", 4, 0, 1, 2, 5, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("str_memw%0d", i), 32'(tr_memw[i]), (i == 3) ? 1 : 0);
            chk($sformatf("str_regw%0d", i), 32'(tr_regw[i]), 0);
        end

        af_fix = 6;
        trace(20'hE2500, 4);
        af_fix = -1;
        chk_states("subs", 4, 0, 1, 7, 8, 0);
        chk("subs_alu_sub", 32'(tr_alu[2]), 1);
        trace(20'h0A000, 3);
        chk_states("beq", 3, 0, 1, 9, 0, 0);
        chk("beq_taken", 32'(tr_pcw[2]), 1);
        trace(20'h1A000, 3);
        chk("bne_not_taken", 32'(tr_pcw[2]), 0);

        af_fix = 0;
        trace(20'hE0910, 4);
        af_fix = -1;
        trace(20'h00821, 4);
        chk("addeq_regw", 32'(tr_regw[3]), 0);
        trace(20'h0A000, 3);
        chk("beq_after_addeq", 32'(tr_pcw[2]), 0);
        trace(20'hE0821, 4);
        chk("addal_regw", 32'(tr_regw[3]), 1);
        chk("addal_alu", 32'(tr_alu[2]), 0);

        trace(20'hEC000, 2);
        chk_states("nop", 2, 0, 1, 0, 0, 0);
        chk("nop_pcw_fetch", 32'(tr_pcw[0]), 1);
        chk("nop_pcw_decode", 32'(tr_pcw[1]), 0);
        chk("nop_irw_decode", 32'(tr_irw[1]), 0);

        af_fix = 6;
        trace(20'hE2500, 4);
        af_fix = -1;
        dir_q.push_back(20'hE5801);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b1);
        #3;
        chk("rst_in_memwr_state", 32'(dbg_state), 5);
        chk("rst_in_memwr_memw", 32'(MemWrite), 0);
        run_cycle(1'b1);
        trace(20'h0A000, 3);
        chk("rst_release_state", 32'(tr_st[0]), 0);
        chk("rst_release_irw", 32'(tr_irw[0]), 1);
        chk("rst_flags_cleared", 32'(tr_pcw[2]), 0);

        for (int k = 0; k < 1500; k++) run_cycle($urandom_range(0, 59) == 0);

        @(negedge clk);
        mode = 0;
        reset = 1'b0;
        force dut.state_q = mc_pkg::state_e'(4'd12);
        #1;
        chk("illegal_state", 32'(dbg_state), 12);
        chk("illegal_pcw", 32'(PCWrite), 0);
        chk("illegal_irw", 32'(IRWrite), 0);
        chk("illegal_memw", 32'(MemWrite), 0);
        chk("illegal_regw", 32'(RegWrite), 0);
        chk("illegal_adr", 32'(AdrSrc), 0);
        release dut.state_q;
        @(negedge clk);
        #1;
        chk("illegal_to_fetch", 32'(dbg_state), 0);
        chk("illegal_to_fetch_irw", 32'(IRWrite), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
